// File: rtl/uart_frac_baud_generator.sv
// uart_frac_baud_generator
// Oversample tick generator for a UART: a cycle counter produces one sample
// tick every divider_i+1 clocks, a phase counter marks the bit centre and
// the bit end. Define UART_BAUD_FRACTIONAL_EN to add a fractional
// accumulator that stretches selected periods by one cycle, giving an
// average period of divider_i+1+fraction_i/2^FRAC_WIDTH.
module uart_frac_baud_generator #(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_WIDTH = 4,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  restart_i,
    input  logic [DIV_WIDTH-1:0]  divider_i,
    input  logic [FRAC_WIDTH-1:0] fraction_i,
    output logic                  sample_o,
    output logic                  mid_bit_o,
    output logic                  bit_tick_o
);

    localparam int PH_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PHASE_MID  = PH_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic                 sample_q, sample_d;
    logic                 mid_bit_q, mid_bit_d;
    logic                 bit_tick_q, bit_tick_d;
    logic [DIV_WIDTH:0]   limit;
    logic                 tick;

`ifdef UART_BAUD_FRACTIONAL_EN
    logic [FRAC_WIDTH-1:0] acc_q, acc_d;
    logic                  stretch_q, stretch_d;
    logic                  carry;

    // Limit widened by one bit so an all-ones divider plus stretch cannot wrap
    always_comb begin
        limit = {1'b0, divider_i} + {{DIV_WIDTH{1'b0}}, stretch_q};
    end
`else
    logic unused_fraction;

    // Fraction is ignored without the accumulator; period is divider_i+1
    always_comb begin
        limit           = {1'b0, divider_i};
        unused_fraction = ^fraction_i;
    end
`endif

    // Next-state: restart clears, disable freezes, otherwise count/tick
    always_comb begin
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        sample_d   = 1'b0;
        mid_bit_d  = 1'b0;
        bit_tick_d = 1'b0;
        tick       = 1'b0;
`ifdef UART_BAUD_FRACTIONAL_EN
        acc_d      = acc_q;
        stretch_d  = stretch_q;
        carry      = 1'b0;
`endif
        if (restart_i) begin
            cnt_d   = '0;
            phase_d = '0;
`ifdef UART_BAUD_FRACTIONAL_EN
            acc_d     = '0;
            stretch_d = 1'b0;
`endif
        end else if (enable_i) begin
            if ({1'b0, cnt_q} >= limit) begin
                tick       = 1'b1;
                cnt_d      = '0;
                sample_d   = 1'b1;
                mid_bit_d  = (phase_q == PHASE_MID);
                bit_tick_d = (phase_q == PHASE_LAST);
                phase_d    = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
`ifdef UART_BAUD_FRACTIONAL_EN
                {carry, acc_d} = {1'b0, acc_q} + {1'b0, fraction_i};
                stretch_d      = carry;
`endif
            end else begin
`ifdef UART_BAUD_FRACTIONAL_EN
                // cnt cannot hold divider+1 when divider is all-ones; spend
                // the stretch cycle by clearing stretch instead of wrapping.
                if (cnt_q == '1) begin
                    stretch_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                cnt_d = cnt_q + 1'b1;
`endif
            end
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            phase_q    <= '0;
            sample_q   <= 1'b0;
            mid_bit_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            sample_q   <= sample_d;
            mid_bit_q  <= mid_bit_d;
            bit_tick_q <= bit_tick_d;
        end
    end

`ifdef UART_BAUD_FRACTIONAL_EN
    // Fractional accumulator and stretch flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q     <= '0;
            stretch_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            stretch_q <= stretch_d;
        end
    end
`endif

    assign sample_o   = sample_q;
    assign mid_bit_o  = mid_bit_q;
    assign bit_tick_o = bit_tick_q;

endmodule

// File: tb/tb_uart_frac_baud_generator.sv
// Directed bench for uart_frac_baud_generator (DIV=16, FRAC=4, OS=16).
// Expectations follow UART_BAUD_FRACTIONAL_EN when it is defined.
module tb_uart_frac_baud_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        restart;
    logic [15:0] divider;
    logic [3:0]  fraction;
    logic        sample;
    logic        mid_bit;
    logic        bit_tick;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_frac_baud_generator #(
        .DIV_WIDTH (16),
        .FRAC_WIDTH(4),
        .OVERSAMPLE(16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .enable_i  (enable),
        .restart_i (restart),
        .divider_i (divider),
        .fraction_i(fraction),
        .sample_o  (sample),
        .mid_bit_o (mid_bit),
        .bit_tick_o(bit_tick)
    );

    // One restart pulse covering exactly one rising edge; returns at the
    // negedge after it, so the next edge is edge 1 after restart.
    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        rst = 1'b1; enable = 1'b0; restart = 1'b0; divider = 16'd3; fraction = 4'd0;
        #2;
        obs = {sample, mid_bit, bit_tick};
        tests++;
        if (obs !== 3'b000) begin
            fails++;
            $display("FAIL reset_init: got %b expected 000", obs);
        end
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        tests++;
        if (sample !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_sample: got %b expected 1", sample);
        end
        // asynchronous assertion between edges
        #2 rst = 1'b1;
        #1;
        obs = {sample, mid_bit, bit_tick};
        tests++;
        if (obs !== 3'b000) begin
            fails++;
            $display("FAIL reset_async: got %b expected 000", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            obs = {sample, mid_bit, bit_tick};
            tests++;
            if (obs !== {(k % 4 == 0), 2'b00}) begin
                fails++;
                $display("FAIL reset_release k=%0d: got %b expected %b", k, obs, {(k % 4 == 0), 2'b00});
            end
        end
    endtask

    task automatic test_integer();
        logic [2:0] obs, exp;
        divider = 16'd3; fraction = 4'd0; enable = 1'b1;
        pulse_restart();
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            obs = {sample, mid_bit, bit_tick};
            exp = {(k % 4 == 0), (k % 64 == 32), (k % 64 == 0)};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL integer k=%0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_fractional();
        logic [2:0] obs, exp;
        int n = 0;
        int nxt = 4;
        int seen = 0;
        int want;
        divider = 16'd3; fraction = 4'd8; enable = 1'b1;
        pulse_restart();
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == nxt) begin
                n++;
                exp = {1'b1, (n % 16 == 8), (n % 16 == 0)};
`ifdef UART_BAUD_FRACTIONAL_EN
                nxt += (n >= 2 && n % 2 == 0) ? 5 : 4;
`else
                nxt += 4;
`endif
            end else begin
                exp = 3'b000;
            end
            obs = {sample, mid_bit, bit_tick};
            if (sample === 1'b1 && k <= 148) seen++;
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL fractional k=%0d: got %b expected %b", k, obs, exp);
            end
        end
`ifdef UART_BAUD_FRACTIONAL_EN
        want = 33;
`else
        want = 37;
`endif
        tests++;
        if (seen !== want) begin
            fails++;
            $display("FAIL fractional_count: got %0d samples expected %0d", seen, want);
        end
        fraction = 4'd0;
    endtask

    task automatic test_divider_change();
        logic [2:0] obs, exp;
        divider = 16'd20; fraction = 4'd0; enable = 1'b1;
        pulse_restart();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            obs = {sample, mid_bit, bit_tick};
            tests++;
            if (obs !== 3'b000) begin
                fails++;
                $display("FAIL divchg_pre k=%0d: got %b expected 000", k, obs);
            end
        end
        divider = 16'd5;
        for (int k = 11; k <= 30; k++) begin
            @(negedge clk);
            obs = {sample, mid_bit, bit_tick};
            exp = {((k - 11) % 6 == 0), 2'b00};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL divchg k=%0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_restart_mid();
        logic [2:0] obs, exp;
        divider = 16'd3; fraction = 4'd0; enable = 1'b1;
        pulse_restart();
        for (int k = 1; k <= 39; k++) @(negedge clk);
        // phase is 9 here; the next edge would otherwise carry sample 10
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        obs = {sample, mid_bit, bit_tick};
        tests++;
        if (obs !== 3'b000) begin
            fails++;
            $display("FAIL restart_cycle: got %b expected 000", obs);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            obs = {sample, mid_bit, bit_tick};
            exp = {(k % 4 == 0), (k == 32), 1'b0};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL restart_mid k=%0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [2:0] obs, exp;
        divider = 16'd3; fraction = 4'd0; enable = 1'b1;
        pulse_restart();
        for (int k = 1; k <= 24; k++) begin
            if (k == 6)  enable = 1'b0;
            if (k == 13) enable = 1'b1;
            @(negedge clk);
            obs = {sample, mid_bit, bit_tick};
            exp = {(k == 4 || k == 15 || k == 19 || k == 23), 2'b00};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL enable_hold k=%0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [2:0] obs, exp;
        divider = 16'd0; fraction = 4'd0; enable = 1'b1;
        pulse_restart();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            obs = {sample, mid_bit, bit_tick};
            exp = {1'b1, (k == 8), (k == 16)};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL div_zero k=%0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_integer();
        test_fractional();
        test_divider_change();
        test_restart_mid();
        test_enable_hold();
        test_div_zero();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
